// File: rtl/bf16_pkg.sv
// Shared widths, fpcsr bit positions and operand-class encoding for the BF16 converter.
package bf16_pkg;

  localparam int BF16_W      = 16;
  localparam int FP32_W      = 32;
  localparam int BF16_EXP_W  = 8;
  localparam int BF16_FRAC_W = 7;
  localparam int FP32_FRAC_W = 23;

  localparam logic [BF16_EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int FPCSR_NV   = 3;
  localparam int FPCSR_INF  = 2;
  localparam int FPCSR_ZERO = 1;
  localparam int FPCSR_SUBN = 0;

  typedef enum logic [2:0] {
    ZERO,
    SUBN,
    NORM,
    INF,
    QNAN,
    SNAN
  } bf16_class_e;

endpackage

// File: rtl/bf16_classify.sv
// Combinational classifier: sorts a BF16 operand into zero, subnormal, normal,
// infinity, quiet NaN or signaling NaN.
module bf16_classify
  import bf16_pkg::*;
(
  input  logic [BF16_W-1:0] operand_a,
  output bf16_class_e       op_class
);

  logic [BF16_EXP_W-1:0]  exp_field;
  logic [BF16_FRAC_W-1:0] frac_field;
  logic                   sign_unused;

  assign sign_unused = operand_a[BF16_W-1];
  assign exp_field   = operand_a[BF16_W-2:BF16_FRAC_W];
  assign frac_field  = operand_a[BF16_FRAC_W-1:0];

  // The fraction MSB distinguishes quiet from signaling NaNs.
  always_comb begin
    op_class = NORM;
    if (exp_field == '0) begin
      op_class = (frac_field == '0) ? ZERO : SUBN;
    end else if (exp_field == EXP_MAX) begin
      if (frac_field == '0) begin
        op_class = INF;
      end else if (frac_field[BF16_FRAC_W-1]) begin
        op_class = QNAN;
      end else begin
        op_class = SNAN;
      end
    end
  end

endmodule

// File: rtl/bf16_to_fp32.sv
// Registered BF16 -> FP32 converter with a 4-bit class/status word (1-cycle latency).
// Define BF16_CVT_DAZ_EN to flush subnormal inputs to signed zero.
module bf16_to_fp32
  import bf16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              instruction_enable,
  input  logic [BF16_W-1:0] operand_a,
  output logic [FP32_W-1:0] result,
  output logic [3:0]        fpcsr
);

  bf16_class_e       op_class;
  logic              sign;
  logic [FP32_W-1:0] widened;
  logic [FP32_W-1:0] result_d, result_q;
  logic [3:0]        fpcsr_d, fpcsr_q;

  bf16_classify u_classify (
    .operand_a (operand_a),
    .op_class  (op_class)
  );

  assign sign    = operand_a[BF16_W-1];
  assign widened = {operand_a, {(FP32_W-BF16_W){1'b0}}};

  always_comb begin
    result_d = result_q;
    fpcsr_d  = fpcsr_q;
    if (instruction_enable) begin
      result_d = widened;
      fpcsr_d  = '0;
      case (op_class)
        ZERO: begin
          result_d                = {sign, {(FP32_W-1){1'b0}}};
          fpcsr_d[FPCSR_ZERO]     = 1'b1;
        end
        SUBN: begin
`ifdef BF16_CVT_DAZ_EN
          result_d                = {sign, {(FP32_W-1){1'b0}}};
          fpcsr_d[FPCSR_ZERO]     = 1'b1;
`endif
          fpcsr_d[FPCSR_SUBN]     = 1'b1;
        end
        INF: begin
          result_d                = {sign, EXP_MAX, {FP32_FRAC_W{1'b0}}};
          fpcsr_d[FPCSR_INF]      = 1'b1;
        end
        SNAN: begin
          // Quiet the NaN by forcing the fraction MSB, keeping the payload.
          result_d                = {sign, EXP_MAX, 1'b1,
                                     operand_a[BF16_FRAC_W-2:0],
                                     {(FP32_W-BF16_W){1'b0}}};
          fpcsr_d[FPCSR_NV]       = 1'b1;
        end
        default: begin
          result_d = widened;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      fpcsr_q  <= '0;
    end else begin
      result_q <= result_d;
      fpcsr_q  <= fpcsr_d;
    end
  end

  assign result = result_q;
  assign fpcsr  = fpcsr_q;

endmodule

// File: tb/tb_bf16_to_fp32.sv
// Self-checking bench for bf16_to_fp32: directed class cases plus randomized
// operands against an arithmetic reference model.
module tb_bf16_to_fp32;

  logic        clk;
  logic        reset;
  logic        instruction_enable;
  logic [15:0] operand_a;
  logic [31:0] result;
  logic [3:0]  fpcsr;

  int total;
  int bad;

  bf16_to_fp32 dut (
    .clk                (clk),
    .reset              (reset),
    .instruction_enable (instruction_enable),
    .operand_a          (operand_a),
    .result             (result),
    .fpcsr              (fpcsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: BF16 is the top half of FP32, so the value is a*2^16 except for
  // zeros, flushed subnormals and signaling NaNs. Returns {fpcsr, result}.
  function automatic logic [35:0] model(input logic [15:0] a);
    int unsigned av, sg, ex, fr;
    logic [31:0] r;
    logic [3:0]  fc;
    av = a;
    sg = av / 32768;
    ex = (av / 128) % 256;
    fr = av % 128;
    r  = av * 65536;
    fc = 4'b0000;
    if (ex == 0 && fr == 0) begin
      r  = sg * 32'h8000_0000;
      fc = 4'b0010;
    end else if (ex == 0) begin
`ifdef BF16_CVT_DAZ_EN
      r  = sg * 32'h8000_0000;
      fc = 4'b0011;
`else
      fc = 4'b0001;
`endif
    end else if (ex == 255 && fr == 0) begin
      fc = 4'b0100;
    end else if (ex == 255 && fr < 64) begin
      r  = (av + 64) * 65536;
      fc = 4'b1000;
    end
    return {fc, r};
  endfunction

  task automatic convert_and_check(input string name, input logic [15:0] op,
                                   input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    operand_a          = op;
    instruction_enable = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (result !== exp_r || fpcsr !== exp_f) begin
      bad++;
      $display("[TB] FAIL %s op=%h: got result=%h fpcsr=%b, want result=%h fpcsr=%b",
               name, op, result, fpcsr, exp_r, exp_f);
    end
  endtask

  task automatic test_reset();
    reset              = 1'b0;
    instruction_enable = 1'b1;
    operand_a          = 16'h3F80;
    repeat (10) begin
      @(posedge clk);
      #1;
      total++;
      if (result !== 32'h0 || fpcsr !== 4'b0) begin
        bad++;
        $display("[TB] FAIL reset_hold: got result=%h fpcsr=%b, want 0/0", result, fpcsr);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    convert_and_check("first_after_reset", 16'h3F80, 32'h3F80_0000, 4'b0000);
  endtask

  task automatic test_hold();
    convert_and_check("hold_setup", 16'h7F80, 32'h7F80_0000, 4'b0100);
    @(negedge clk);
    instruction_enable = 1'b0;
    operand_a          = 16'h0000;
    repeat (3) begin
      @(posedge clk);
      #1;
      total++;
      if (result !== 32'h7F80_0000 || fpcsr !== 4'b0100) begin
        bad++;
        $display("[TB] FAIL hold: got result=%h fpcsr=%b, want 7f800000/0100", result, fpcsr);
      end
      @(negedge clk);
      operand_a = 16'(operand_a + 16'h1234);
    end
  endtask

  task automatic test_specials();
    convert_and_check("pos_zero", 16'h0000, 32'h0000_0000, 4'b0010);
    convert_and_check("pos_inf",  16'h7F80, 32'h7F80_0000, 4'b0100);
    convert_and_check("neg_inf",  16'hFF80, 32'hFF80_0000, 4'b0100);
    convert_and_check("neg_zero", 16'h8000, 32'h8000_0000, 4'b0010);
    convert_and_check("qnan",     16'h7FC0, 32'h7FC0_0000, 4'b0000);
    convert_and_check("snan_pos", 16'h7F81, 32'h7FC1_0000, 4'b1000);
    convert_and_check("snan_neg", 16'hFFA0, 32'hFFE0_0000, 4'b1000);
  endtask

  task automatic test_subnormal();
`ifdef BF16_CVT_DAZ_EN
    convert_and_check("subn_min", 16'h0001, 32'h0000_0000, 4'b0011);
    convert_and_check("subn_neg", 16'h807F, 32'h8000_0000, 4'b0011);
`else
    convert_and_check("subn_min", 16'h0001, 32'h0001_0000, 4'b0001);
    convert_and_check("subn_neg", 16'h807F, 32'h807F_0000, 4'b0001);
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] ops  [4] = '{16'h3C00, 16'h3555, 16'hB555, 16'h3F80};
    logic [31:0] exps [4] = '{32'h3C00_0000, 32'h3555_0000, 32'hB555_0000, 32'h3F80_0000};
    @(negedge clk);
    instruction_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      operand_a = ops[i];
      @(posedge clk);
      #1;
      total++;
      if (result !== exps[i] || fpcsr !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL back_to_back[%0d]: got result=%h fpcsr=%b, want %h/0000",
                 i, result, fpcsr, exps[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [35:0] expv;
    logic [15:0] op;
    logic        en;
    expv = {fpcsr, result};
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      op = 16'($urandom);
      case ($urandom_range(0, 3))
        0: op[14:7] = 8'h00;
        1: op[14:7] = 8'hFF;
        default: ;
      endcase
      en                 = ($urandom_range(0, 3) != 0);
      operand_a          = op;
      instruction_enable = en;
      if (en) expv = model(op);
      @(posedge clk);
      #1;
      total++;
      if (result !== expv[31:0] || fpcsr !== expv[35:32]) begin
        bad++;
        $display("[TB] FAIL random[%0d] op=%h en=%b: got result=%h fpcsr=%b, want %h/%b",
                 i, op, en, result, fpcsr, expv[31:0], expv[35:32]);
      end
    end
  endtask

  task automatic test_async_reset();
    convert_and_check("pre_async", 16'hBF80, 32'hBF80_0000, 4'b0000);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (result !== 32'h0 || fpcsr !== 4'b0) begin
      bad++;
      $display("[TB] FAIL async_clear: got result=%h fpcsr=%b, want 0/0", result, fpcsr);
    end
    @(negedge clk);
    reset = 1'b1;
    convert_and_check("post_async", 16'h4000, 32'h4000_0000, 4'b0000);
  endtask

  initial begin
    total              = 0;
    bad                = 0;
    reset              = 1'b0;
    instruction_enable = 1'b0;
    operand_a          = '0;
    test_reset();
    test_hold();
    test_specials();
    test_subnormal();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf16_to_fp32.md
Name: bf16_to_fp32

Overview:
- Registered converter from a BF16 operand to IEEE-754 binary32, used as a format-conversion unit inside the BF16 accelerator datapath.
- The conversion is exact because BF16 and FP32 share sign and exponent layout; the 7-bit fraction is zero-extended by 16 bits.
- Also reports a 4-bit status/class word (fpcsr) for the converted operand.
- Issue is gated by instruction_enable.

Parameters:
- None. All widths are fixed: 16-bit input, 32-bit output, 4-bit fpcsr.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- instruction_enable  input  1  when 1, capture and convert operand_a this cycle
- operand_a  input  16  BF16 operand: [15] sign, [14:7] exponent, [6:0] fraction
- result  output  32  FP32 result, registered
- fpcsr  output  4  status flags, registered: [3] NV (invalid, signaling-NaN input), [2] INF, [1] ZERO, [0] SUBN

Behaviour:
- Reset (reset==0, asynchronous): result=32'h0000_0000, fpcsr=4'b0000. Outputs stay at these values while reset is held.
- Latency: 1 cycle.
  - On a rising clk edge with reset==1 and instruction_enable==1, result and fpcsr take the conversion of the operand_a value sampled at that edge.
  - With instruction_enable==0, result and fpcsr hold their previous values.
- fpcsr is not sticky; every enabled cycle overwrites all 4 bits.
- Conversion rules (s=operand_a[15], e=operand_a[14:7], f=operand_a[6:0]):
  - Zero (e==0, f==0): result = {s, 31'b0}; fpcsr = 4'b0010.
  - Subnormal (e==0, f!=0): result = {operand_a, 16'h0000}, an exact FP32 subnormal; fpcsr = 4'b0001.
  - Normal (0<e<255): result = {operand_a, 16'h0000}; fpcsr = 4'b0000.
  - Infinity (e==255, f==0): result = {s, 8'hFF, 23'b0}; fpcsr = 4'b0100.
  - Quiet NaN (e==255, f[6]==1): result = {operand_a, 16'h0000}, payload and sign preserved; fpcsr = 4'b0000.
  - Signaling NaN (e==255, f[6]==0, f!=0): result = {s, 8'hFF, 1'b1, f[5:0], 16'h0000}, i.e. quieted with payload preserved; fpcsr = 4'b1000.
- Sign is always propagated unchanged, including for zero, infinity and NaN.
- Reset asserted mid-operation clears the outputs immediately. The first enabled edge after reset release produces a valid result.
- No backpressure or handshake; a new operand may be accepted every cycle.

Optional Feature:
- Macro BF16_CVT_DAZ_EN (denormals-are-zero).
- Defined: a subnormal input produces result = {s, 31'b0}; fpcsr = 4'b0011 (SUBN and ZERO).
- Undefined: subnormals convert exactly as stated in Behaviour.
- All other classes are unaffected either way.

Decomposition:
- Package bf16_pkg holds:
  - BF16_W=16, FP32_W=32, BF16_EXP_W=8, BF16_FRAC_W=7, FP32_FRAC_W=23
  - EXP_MAX=8'hFF
  - fpcsr bit indices FPCSR_NV=3, FPCSR_INF=2, FPCSR_ZERO=1, FPCSR_SUBN=0
  - an enum for the operand class: ZERO, SUBN, NORM, INF, QNAN, SNAN
- One combinational sub-module, bf16_classify: takes operand_a and returns the class enum.
- The top level maps the class to the result and fpcsr and owns the output registers.

Test Plan:
- Reset and hold: reset=0 for 100 ns with instruction_enable=1 -> result=0x00000000, fpcsr=0. With instruction_enable=0 after a conversion, outputs hold across 3 edges.
- Zero and infinities: 0x0000 -> 0x00000000, fpcsr 0010. 0x7F80 -> 0x7F800000, fpcsr 0100. 0xFF80 -> 0xFF800000, fpcsr 0100. 0x8000 -> 0x80000000, fpcsr 0010.
- NaNs: 0x7FC0 -> 0x7FC00000, fpcsr 0000. 0x7F81 -> 0x7FC10000, fpcsr 1000. 0xFFA0 -> 0xFFE00000, fpcsr 1000.
- Normals, back-to-back one per cycle, checked with 1-cycle latency:
  - 0x3C00 -> 0x3C000000
  - 0x3555 -> 0x35550000
  - 0xB555 -> 0xB5550000
  - 0x3F80 -> 0x3F800000
  - fpcsr 0000 for all
- Subnormal:
  - 0x0001 -> 0x00010000, fpcsr 0001; with BF16_CVT_DAZ_EN -> 0x00000000, fpcsr 0011.
  - 0x807F -> 0x807F0000, fpcsr 0001; with BF16_CVT_DAZ_EN -> 0x80000000, fpcsr 0011.
- Async reset mid-stream: assert reset between clock edges -> outputs clear immediately without waiting for a clock edge. After release, the next enabled operand 0x4000 -> 0x40000000.
